apc_serial_frontend: RTL

Engine-side receive/transmit front-end of the APC AES block. It deserializes the 612-bit bit-serial load frame driven by the boot-control APC wrapper into a 256-bit key and a 128-bit plaintext. It runs one start/done handshake with the parallel AES-256 engine, then returns the 128-bit ciphertext bit-serially, bit 0 first, with a valid strobe. One instance sits between the wrapper's serial lines and the AES core.

---
 rtl/apc_pkg.sv | 20 ++
 rtl/apc_bit_serializer.sv | 64 ++++++
 rtl/apc_serial_frontend.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/apc_pkg.sv
// Shared constants and state encoding for the APC serial front-end.
package apc_pkg;

  localparam int FRAME_BITS = 612;
  localparam int KEY_BITS   = 256;
  localparam int BLOCK_BITS = 128;

  localparam int KEY_LSB = 0;
  localparam int PT_LSB  = 256;
  localparam int RSV_LSB = 384;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } apc_fe_state_t;

endpackage

// File: rtl/apc_bit_serializer.sv
// 128-bit parallel-in serial-out shifter, LSB first, exactly BLOCK_BITS valid cycles per load.
module apc_bit_serializer
  import apc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BLOCK_BITS-1:0] din,
  input  logic                  abort,
  output logic                  dout,
  output logic                  dout_valid
);

  localparam logic [7:0] REM_LOAD = 8'(BLOCK_BITS - 1);

  logic [BLOCK_BITS-1:0] shift_q, shift_d;
  logic [7:0]            rem_q, rem_d;
  logic                  dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;

  always_comb begin
    shift_d      = shift_q;
    rem_d        = rem_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (abort) begin
      rem_d        = '0;
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
    end else if (load) begin
      // bit 0 goes straight to the output flop; the rest wait in the shifter
      shift_d      = {1'b0, din[BLOCK_BITS-1:1]};
      dout_d       = din[0];
      dout_valid_d = 1'b1;
      rem_d        = REM_LOAD;
    end else if (rem_q != 8'd0) begin
      shift_d      = {1'b0, shift_q[BLOCK_BITS-1:1]};
      dout_d       = shift_q[0];
      dout_valid_d = 1'b1;
      rem_d        = rem_q - 8'd1;
    end else begin
      dout_d       = 1'b0;
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q      <= '0;
      rem_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      shift_q      <= shift_d;
      rem_q        <= rem_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: rtl/apc_serial_frontend.sv
// Engine-side APC front-end: deserializes the load frame, runs one AES handshake,
// and returns the ciphertext bit-serially.
//
// state    | meaning
// ST_IDLE  | asleep, waiting for frame bit 0
// ST_LOAD  | collecting frame bits, waiting for word_en commit
// ST_START | one-cycle aes_start pulse
// ST_WAIT  | waiting for aes_done
// ST_OUT   | serializer streaming ciphertext
module apc_serial_frontend
  import apc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  data_in_valid,
  input  logic                  word_en,
  input  logic                  core_reset,
  output logic                  data_req,
  output logic                  sleep_out,
  output logic                  data_out,
  output logic                  data_out_valid,
  output logic                  frame_err,
  output logic [KEY_BITS-1:0]   aes_key,
  output logic [BLOCK_BITS-1:0] aes_pt,
  output logic                  aes_start,
  input  logic                  aes_done,
  input  logic [BLOCK_BITS-1:0] aes_ct
);

  localparam logic [9:0] CNT_FULL  = 10'(FRAME_BITS);
  localparam logic [9:0] CNT_PT    = 10'(PT_LSB);
  localparam logic [9:0] CNT_RSV   = 10'(RSV_LSB);
  localparam logic [6:0] OIDX_LAST = 7'(BLOCK_BITS - 1);

  apc_fe_state_t         state_q, state_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [6:0]            oidx_q, oidx_d;
  logic [KEY_BITS-1:0]   key_q, key_d;
  logic [BLOCK_BITS-1:0] pt_q, pt_d;
  logic                  frame_err_q, frame_err_d;
  logic                  word_en_q, word_en_d;

  logic       we_rise;
  logic       abort;
  logic       ser_load;
  logic       wr_en;
  logic [9:0] wr_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    oidx_d      = oidx_q;
    key_d       = key_q;
    pt_d        = pt_q;
    frame_err_d = frame_err_q;
    word_en_d   = word_en;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    we_rise     = word_en & ~word_en_q;
    abort       = core_reset & ((state_q == ST_START) | (state_q == ST_WAIT) | (state_q == ST_OUT));
    ser_load    = (state_q == ST_WAIT) & aes_done & ~core_reset;

    case (state_q)
      ST_IDLE: begin
        if (data_in_valid) begin
          wr_en       = 1'b1;
          wr_idx      = '0;
          cnt_d       = 10'd1;
          frame_err_d = 1'b0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (data_in_valid) begin
          if (cnt_q == CNT_FULL) begin
            frame_err_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            cnt_d = cnt_q + 10'd1;
          end
        end
        if (we_rise) begin
          if (cnt_q == CNT_FULL) begin
            state_d = ST_START;
          end else begin
            frame_err_d = 1'b1;
            cnt_d       = '0;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (aes_done) begin
          oidx_d  = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        oidx_d = oidx_q + 7'd1;
        if (oidx_q == OIDX_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // an abort that coincides with a valid bit treats that bit as the next frame's bit 0
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      oidx_d  = '0;
      if (data_in_valid) begin
        wr_en       = 1'b1;
        wr_idx      = '0;
        cnt_d       = 10'd1;
        frame_err_d = 1'b0;
        state_d     = ST_LOAD;
      end
    end

    // field offsets are power-of-two aligned, so the low index bits address each field directly
    if (wr_en) begin
      if (wr_idx < CNT_PT) begin
        key_d[wr_idx[7:0]] = data_in;
      end else if (wr_idx < CNT_RSV) begin
        pt_d[wr_idx[6:0]] = data_in;
      end else if (data_in) begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      oidx_q      <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      frame_err_q <= 1'b0;
      word_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oidx_q      <= oidx_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      frame_err_q <= frame_err_d;
      word_en_q   <= word_en_d;
    end
  end

  apc_bit_serializer u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .din        (aes_ct),
    .abort      (abort),
    .dout       (data_out),
    .dout_valid (data_out_valid)
  );

  assign data_req  = (state_q == ST_IDLE) | (state_q == ST_LOAD);
  assign sleep_out = (state_q == ST_IDLE);
  assign aes_start = (state_q == ST_START);
  assign frame_err = frame_err_q;
  assign aes_key   = key_q;
  assign aes_pt    = pt_q;

endmodule
